// File: rtl/sa_result_buffer_if.sv
// Result-buffer bus: SA capture inputs, consumer valid/ready drain, host best-result readback.
interface sa_result_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 10,
  parameter int unsigned XW    = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          clr;
  logic          done;
  logic [TW-1:0] target;
  logic [XW-1:0] x;
  logic [TW-1:0] y;
  logic          out_ready;
  logic          out_valid;
  logic [TW-1:0] out_target;
  logic [XW-1:0] out_x;
  logic [TW-1:0] out_y;
  logic [TW:0]   out_err;
  logic [CW-1:0] count;
  logic          overflow;
  logic          best_valid;
  logic [XW-1:0] best_x;
  logic [TW:0]   best_err;

  modport master (
    output clr, done, target, x, y, out_ready,
    input  out_valid, out_target, out_x, out_y, out_err, count, overflow,
           best_valid, best_x, best_err
  );

  modport slave (
    input  clr, done, target, x, y, out_ready,
    output out_valid, out_target, out_x, out_y, out_err, count, overflow,
           best_valid, best_x, best_err
  );
endinterface

// File: rtl/sa_result_buffer.sv
// Captures SA results on done rising edge into a show-ahead FIFO with residual,
// and tracks the minimum-|err| capture since reset/clr.
module sa_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 10,
  parameter int unsigned XW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  sa_result_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = TW + 1;

  typedef struct packed {
    logic [TW-1:0] target;
    logic [XW-1:0] x;
    logic [TW-1:0] y;
    logic [EW-1:0] err;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_done_d;
  logic          r_best_valid;
  logic [XW-1:0] r_best_x;
  logic [EW-1:0] r_best_err;

  logic          w_cap;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [EW-1:0] w_err;
  logic [EW-1:0] w_abs_err;
  logic [EW-1:0] w_best_abs;
  logic          w_best_upd;

  // Capture/pop qualification; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    w_cap      = bus.done & ~r_done_d;
    w_full     = (r_count == CW'(DEPTH));
    w_pop      = (r_count != '0) & bus.out_ready;
    w_push     = w_cap & (~w_full | w_pop);
    w_err      = {1'b0, bus.target} - {1'b0, bus.y};
    w_abs_err  = w_err[EW-1] ? EW'(-w_err) : w_err;
    w_best_abs = r_best_err[EW-1] ? EW'(-r_best_err) : r_best_err;
    w_best_upd = w_cap & (~r_best_valid | (w_abs_err < w_best_abs));
  end

  // Edge detector runs through clr so a held done cannot re-capture afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done_d <= 1'b0;
    else       r_done_d <= bus.done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_best_valid <= 1'b0;
      r_best_x     <= '0;
      r_best_err   <= '0;
    end else if (bus.clr) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_best_valid <= 1'b0;
      r_best_x     <= '0;
      r_best_err   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{target: bus.target, x: bus.x, y: bus.y, err: w_err};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_cap && !w_push) r_overflow <= 1'b1;
      if (w_best_upd) begin
        r_best_valid <= 1'b1;
        r_best_x     <= bus.x;
        r_best_err   <= w_err;
      end
    end
  end

  // Show-ahead head slot.
  assign bus.out_valid  = (r_count != '0);
  assign bus.out_target = r_mem[r_rd_ptr].target;
  assign bus.out_x      = r_mem[r_rd_ptr].x;
  assign bus.out_y      = r_mem[r_rd_ptr].y;
  assign bus.out_err    = r_mem[r_rd_ptr].err;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.best_valid = r_best_valid;
  assign bus.best_x     = r_best_x;
  assign bus.best_err   = r_best_err;
endmodule

// File: tb/tb_sa_result_buffer.sv
// Directed bench for sa_result_buffer: capture, drain, overflow, best tracking, clr and reset.
module tb_sa_result_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 10;
  localparam int unsigned XW    = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  sa_result_buffer_if #(.DEPTH(DEPTH), .TW(TW), .XW(XW)) bus ();

  sa_result_buffer #(.DEPTH(DEPTH), .TW(TW), .XW(XW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int t, input int xv, input int yv);
    bus.target = TW'(t);
    bus.x      = XW'(xv);
    bus.y      = TW'(yv);
    bus.done   = 1'b1;
    tick();
    bus.done   = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.clr = 1'b0; bus.done = 1'b0; bus.target = '0; bus.x = '0; bus.y = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_bvalid", 32'(bus.best_valid), 32'd0);
    chk("rst_bx", 32'(bus.best_x), 32'd0);
    chk("rst_berr", 32'(bus.best_err), 32'd0);
    chk("rst_otgt", 32'(bus.out_target), 32'd0);
    chk("rst_oerr", 32'(bus.out_err), 32'd0);
    reset = 1'b0;
    tick();

    // Test 1: single-cycle done
    bus.target = 10'd550; bus.x = 8'd23; bus.y = 10'd548; bus.done = 1'b1;
    tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_x", 32'(bus.out_x), 32'd23);
    chk("t1_y", 32'(bus.out_y), 32'd548);
    chk("t1_err", 32'(bus.out_err), 32'd2);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_bx", 32'(bus.best_x), 32'd23);
    chk("t1_berr", 32'(bus.best_err), 32'd2);
    chk("t1_bvalid", 32'(bus.best_valid), 32'd1);
    bus.done = 1'b0;
    tick();

    // Test 2: done held 5 cycles -> one capture
    bus.target = 10'd800; bus.x = 8'd28; bus.y = 10'd803; bus.done = 1'b1;
    repeat (5) tick();
    bus.done = 1'b0;
    tick();
    chk("t2_count", 32'(bus.count), 32'd2);
    chk("t2_head", 32'(bus.out_target), 32'd550);
    chk("t2_bx", 32'(bus.best_x), 32'd23);
    chk("t2_berr", 32'(bus.best_err), 32'd2);

    // Test 3: drain in order, then ready on empty
    bus.out_ready = 1'b1;
    tick();
    chk("t3_tgt1", 32'(bus.out_target), 32'd800);
    chk("t3_x1", 32'(bus.out_x), 32'd28);
    chk("t3_err1", 32'(bus.out_err), 32'h7FD);
    chk("t3_cnt1", 32'(bus.count), 32'd1);
    tick();
    chk("t3_cnt0", 32'(bus.count), 32'd0);
    chk("t3_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_ovf", 32'(bus.overflow), 32'd0);
    tick();
    chk("t3_empty_rdy", 32'(bus.count), 32'd0);
    bus.out_ready = 1'b0;

    // Test 4: overfill, then capture concurrent with pop while full
    for (int k = 1; k <= 5; k++) pulse(200, k, 200 - k);
    chk("t4_count", 32'(bus.count), 32'd4);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    chk("t4_head_x", 32'(bus.out_x), 32'd1);
    chk("t4_berr", 32'(bus.best_err), 32'd1);
    chk("t4_bx", 32'(bus.best_x), 32'd1);
    bus.target = 10'd200; bus.x = 8'd6; bus.y = 10'd194;
    bus.done = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.done = 1'b0; bus.out_ready = 1'b0;
    chk("t4_cnt_full", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    begin
      int exp_x [4] = '{2, 3, 4, 6};
      for (int i = 0; i < 4; i++) begin
        chk("t4_drain_x", 32'(bus.out_x), 32'(exp_x[i]));
        chk("t4_drain_err", 32'(bus.out_err), 32'(exp_x[i]));
        tick();
      end
    end
    bus.out_ready = 1'b0;
    chk("t4_drained", 32'(bus.count), 32'd0);
    chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Test 5: clr, then tie/improvement in best tracker
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("t5_clr_bvalid", 32'(bus.best_valid), 32'd0);
    chk("t5_clr_ovf", 32'(bus.overflow), 32'd0);
    pulse(300, 40, 296);
    chk("t5_b1_err", 32'(bus.best_err), 32'd4);
    chk("t5_b1_x", 32'(bus.best_x), 32'd40);
    pulse(300, 41, 304);
    chk("t5_tie_err", 32'(bus.best_err), 32'd4);
    chk("t5_tie_x", 32'(bus.best_x), 32'd40);
    pulse(300, 42, 299);
    chk("t5_imp_err", 32'(bus.best_err), 32'd1);
    chk("t5_imp_x", 32'(bus.best_x), 32'd42);
    chk("t5_count", 32'(bus.count), 32'd3);

    // Test 6: clr coincident with done rising edge
    bus.target = 10'd100; bus.x = 8'd9; bus.y = 10'd100;
    bus.done = 1'b1; bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_ovf", 32'(bus.overflow), 32'd0);
    chk("t6_bvalid", 32'(bus.best_valid), 32'd0);
    chk("t6_bx", 32'(bus.best_x), 32'd0);
    chk("t6_berr", 32'(bus.best_err), 32'd0);
    repeat (2) tick();
    chk("t6_no_recap", 32'(bus.count), 32'd0);
    chk("t6_no_best", 32'(bus.best_valid), 32'd0);
    bus.done = 1'b0;
    tick();

    // Async reset mid-stream, with done high across deassertion
    pulse(500, 7, 490);
    chk("t7_pre_count", 32'(bus.count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t7_async_count", 32'(bus.count), 32'd0);
    chk("t7_async_valid", 32'(bus.out_valid), 32'd0);
    chk("t7_async_bvalid", 32'(bus.best_valid), 32'd0);
    chk("t7_async_berr", 32'(bus.best_err), 32'd0);
    bus.target = 10'd0; bus.x = 8'd77; bus.y = 10'd1023; bus.done = 1'b1;
    #2 reset = 1'b0;
    tick();
    chk("t7_edge_count", 32'(bus.count), 32'd1);
    chk("t7_min_err", 32'(bus.out_err), 32'h401);
    chk("t7_best_err", 32'(bus.best_err), 32'h401);
    chk("t7_best_x", 32'(bus.best_x), 32'd77);
    bus.done = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
